// File: rtl/sample_writer.sv
// rtl/sample_writer.sv - write side of the 7-bit sample memory: packs (x1, x2, t) into three words per sample
module sample_writer #(
    parameter int MAX_SAMPLES = 100,
    parameter int ADDR_W      = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [6:0]        s_x1,
    input  logic [6:0]        s_x2,
    input  logic [1:0]        s_t,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [6:0]        mem_data,
    output logic [ADDR_W-1:0] sample_count,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err_target
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WX1, S_WX2, S_WT, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_SAMPLES);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO     = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] THREE   = ADDR_W'(3);

    state_t            state_q, state_d;
    logic [6:0]        x2_q, x2_d;
    logic [1:0]        t_q, t_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [6:0]        data_q, data_d;
    logic              we_q, we_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              full_q, full_d;
    logic              err_q, err_d;

    // Outputs are registered from the next state, so each write lands in the cycle its state is entered.
    always_comb begin
        state_d = state_q;
        x2_d    = x2_q;
        t_d     = t_q;
        last_d  = last_q;
        base_d  = base_q;
        count_d = count_q;
        full_d  = full_q;
        done_d  = done_q;
        err_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        if (start) begin
            count_d = '0;
            base_d  = '0;
            full_d  = 1'b0;
            done_d  = 1'b0;
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (s_valid && ready_q) begin
                        x2_d   = s_x2;
                        t_d    = s_t;
                        last_d = s_last;
                        // Legal targets are +1 (01) and -1 (11): both have bit 0 set.
                        if (s_t[0]) begin
                            state_d = S_WX1;
                            we_d    = 1'b1;
                            addr_d  = base_q;
                            data_d  = s_x1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_WX1: begin
                    state_d = S_WX2;
                    we_d    = 1'b1;
                    addr_d  = base_q + ONE;
                    data_d  = x2_q;
                end
                S_WX2: begin
                    state_d = S_WT;
                    we_d    = 1'b1;
                    addr_d  = base_q + TWO;
                    data_d  = {{5{t_q[1]}}, t_q};
                end
                S_WT: begin
                    count_d = count_q + ONE;
                    base_d  = base_q + THREE;
                    if (count_q + ONE == MAX_CNT) begin
                        state_d = S_DONE;
                        full_d  = 1'b1;
                        done_d  = 1'b1;
                    end else if (last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                default: state_d = state_q;
            endcase
        end
        ready_d = (state_d == S_LOAD);
        busy_d  = (state_d == S_LOAD) || (state_d == S_WX1) ||
                  (state_d == S_WX2)  || (state_d == S_WT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x2_q    <= '0;
            t_q     <= '0;
            last_q  <= 1'b0;
            base_q  <= '0;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x2_q    <= x2_d;
            t_q     <= t_d;
            last_q  <= last_d;
            base_q  <= base_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign s_ready      = ready_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_data     = data_q;
    assign sample_count = count_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign full         = full_q;
    assign err_target   = err_q;

endmodule

// File: tb/tb_sample_writer.sv
// tb/tb_sample_writer.sv - self-checking bench for sample_writer
module tb_sample_writer;

    localparam int MAXS = 4;
    localparam int AW   = 9;

    logic          clk, rst, start, s_valid, s_ready, s_last;
    logic [6:0]    s_x1, s_x2, mem_data;
    logic [1:0]    s_t;
    logic          mem_we, busy, done, full, err_target;
    logic [AW-1:0] mem_addr, sample_count;

    sample_writer #(.MAX_SAMPLES(MAXS), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_x1(s_x1), .s_x2(s_x2), .s_t(s_t), .s_last(s_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .sample_count(sample_count), .busy(busy), .done(done), .full(full),
        .err_target(err_target)
    );

    typedef struct {
        logic [6:0] x1;
        logic [6:0] x2;
        logic [1:0] t;
        logic       last;
        logic [6:0] e0;
        logic [6:0] e1;
        logic [6:0] e2;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    int n_errp   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (mem_we === 1'b1) n_writes++;
        if (err_target === 1'b1) n_errp++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ready", {31'd0, s_ready}, 1);
        chk("start_count", {23'd0, sample_count}, 0);
        chk("start_done_full", {30'd0, done, full}, 0);
    endtask

    function automatic logic [6:0] t_word(input logic [1:0] t);
        return (t == 2'b11) ? 7'h7F : 7'h01;
    endfunction

    // Offers one sample as the k-th stored sample and checks the write burst / rejection timing.
    task automatic send(input logic [6:0] x1, input logic [6:0] x2, input logic [1:0] t,
                        input logic last, input int k, input logic legal,
                        input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
        int w;
        logic [6:0] ed [3];
        ed[0] = e0; ed[1] = e1; ed[2] = e2;
        w = 0;
        while (s_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        chk("ready_wait", {31'd0, (w < 20)}, 1);
        s_valid = 1'b1; s_x1 = x1; s_x2 = x2; s_t = t; s_last = last;
        step();
        s_valid = 1'b0;
        if (legal) begin
            for (int j = 0; j < 3; j++) begin
                chk("wr_we", {31'd0, mem_we}, 1);
                chk("wr_addr", {23'd0, mem_addr}, 3 * k + j);
                chk("wr_data", {25'd0, mem_data}, {25'd0, ed[j]});
                chk("wr_ready_low", {31'd0, s_ready}, 0);
                step();
            end
            chk("count_after", {23'd0, sample_count}, k + 1);
            chk("no_we_after", {31'd0, mem_we}, 0);
        end else begin
            chk("err_pulse", {31'd0, err_target}, 1);
            chk("err_no_we", {31'd0, mem_we}, 0);
            chk("err_ready", {31'd0, s_ready}, 1);
            chk("err_count", {23'd0, sample_count}, k);
            step();
            chk("err_once", {31'd0, err_target}, 0);
        end
    endtask

    task automatic send_legal(input logic [6:0] x1, input logic [6:0] x2, input logic [1:0] t,
                              input logic last, input int k);
        send(x1, x2, t, last, k, 1'b1, x1, x2, t_word(t));
    endtask

    vec_t vecs [3];
    int   wr0, ep0, k;

    initial begin
        vecs[0] = '{x1: 7'd5,    x2: 7'h7D, t: 2'b01, last: 1'b0, e0: 7'h05, e1: 7'h7D, e2: 7'h01};
        vecs[1] = '{x1: 7'h40,   x2: 7'h3F, t: 2'b11, last: 1'b0, e0: 7'h40, e1: 7'h3F, e2: 7'h7F};
        vecs[2] = '{x1: 7'd0,    x2: 7'd1,  t: 2'b01, last: 1'b1, e0: 7'h00, e1: 7'h01, e2: 7'h01};

        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_x1 = '0; s_x2 = '0; s_t = '0; s_last = 1'b0;
        step(); step();
        chk("rst_outputs", {s_ready, mem_we, busy, done, full, err_target}, 0);
        chk("rst_addr_data", {mem_addr, mem_data}, 0);
        chk("rst_count", {23'd0, sample_count}, 0);
        rst = 1'b0;

        // s_valid ignored in IDLE
        wr0 = n_writes;
        s_valid = 1'b1; s_t = 2'b01;
        for (int i = 0; i < 4; i++) step();
        s_valid = 1'b0;
        chk("idle_no_write", n_writes - wr0, 0);
        chk("idle_not_ready", {31'd0, s_ready}, 0);

        // three-sample load from the table
        pulse_start();
        for (int i = 0; i < 3; i++)
            send(vecs[i].x1, vecs[i].x2, vecs[i].t, vecs[i].last, i, 1'b1,
                 vecs[i].e0, vecs[i].e1, vecs[i].e2);
        chk("t1_done", {31'd0, done}, 1);
        chk("t1_full", {31'd0, full}, 0);
        chk("t1_busy", {31'd0, busy}, 0);
        chk("t1_ready", {31'd0, s_ready}, 0);

        // s_valid ignored in DONE
        wr0 = n_writes;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        s_valid = 1'b0;
        chk("done_no_write", n_writes - wr0, 0);
        chk("done_hold", {30'd0, done, s_ready}, 2);
        chk("done_count", {23'd0, sample_count}, 3);

        // capacity: six samples offered back to back, only MAXS stored
        pulse_start();
        for (int i = 0; i < MAXS; i++)
            send_legal(7'(i + 10), 7'(i + 20), 2'b11, 1'b0, i);
        chk("cap_full", {31'd0, full}, 1);
        chk("cap_done", {31'd0, done}, 1);
        wr0 = n_writes;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("cap_ready_low", {31'd0, s_ready}, 0);
        end
        s_valid = 1'b0;
        chk("cap_no_write", n_writes - wr0, 0);
        chk("cap_count", {23'd0, sample_count}, MAXS);

        // illegal target between two legal samples
        pulse_start();
        ep0 = n_errp;
        wr0 = n_writes;
        send_legal(7'd1, 7'd2, 2'b01, 1'b0, 0);
        send(7'd9, 7'd9, 2'b10, 1'b0, 1, 1'b0, 7'd0, 7'd0, 7'd0);
        send_legal(7'h33, 7'h44, 2'b11, 1'b1, 1);
        chk("ill_err_once", n_errp - ep0, 1);
        chk("ill_writes", n_writes - wr0, 6);
        chk("ill_count", {23'd0, sample_count}, 2);

        // start in WX2 of the second sample
        pulse_start();
        send_legal(7'd7, 7'd8, 2'b01, 1'b0, 0);
        s_valid = 1'b1; s_x1 = 7'd11; s_x2 = 7'd12; s_t = 2'b01; s_last = 1'b0;
        step();
        s_valid = 1'b0;
        step();
        chk("wx2_addr", {23'd0, mem_addr}, 4);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("abort_no_we", {31'd0, mem_we}, 0);
        chk("abort_count", {23'd0, sample_count}, 0);
        chk("abort_ready", {31'd0, s_ready}, 1);
        send_legal(7'd21, 7'd22, 2'b11, 1'b0, 0);

        // start beats a same-cycle handshake
        s_valid = 1'b1; start = 1'b1; s_t = 2'b01;
        step();
        s_valid = 1'b0; start = 1'b0;
        chk("start_prio_we", {31'd0, mem_we}, 0);
        chk("start_prio_count", {23'd0, sample_count}, 0);

        // rst during WT
        send_legal(7'd3, 7'd4, 2'b01, 1'b0, 0);
        s_valid = 1'b1; s_x1 = 7'd5; s_x2 = 7'd6; s_t = 2'b11; s_last = 1'b0;
        step();
        s_valid = 1'b0;
        step(); step();
        chk("wt_addr", {23'd0, mem_addr}, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_wt_flags", {s_ready, mem_we, busy, done, full, err_target}, 0);
        chk("rst_wt_addr_data", {mem_addr, mem_data}, 0);
        chk("rst_wt_count", {23'd0, sample_count}, 0);

        // randomized rounds against a transaction-level model
        for (int r = 0; r < 25; r++) begin
            logic [6:0] rx1, rx2;
            logic [1:0] rt;
            logic       rl, ended;
            pulse_start();
            k = 0;
            ended = 1'b0;
            ep0 = n_errp;
            for (int o = 0; o < 12 && !ended; o++) begin
                int gap;
                int e_before;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) step();
                rx1 = 7'($urandom);
                rx2 = 7'($urandom);
                rt  = ($urandom_range(0, 3) == 0) ? {1'($urandom), 1'b0} : {1'($urandom), 1'b1};
                rl  = ($urandom_range(0, 7) == 0);
                e_before = n_errp;
                if (rt[0]) begin
                    send_legal(rx1, rx2, rt, rl, k);
                    k++;
                    if (k == MAXS || rl) ended = 1'b1;
                    chk("rnd_done", {31'd0, done}, {31'd0, ended});
                    chk("rnd_full", {31'd0, full}, {31'd0, (k == MAXS)});
                    chk("rnd_ready", {31'd0, s_ready}, {31'd0, !ended});
                end else begin
                    send(rx1, rx2, rt, rl, k, 1'b0, 7'd0, 7'd0, 7'd0);
                    chk("rnd_err_count", n_errp - e_before, 1);
                end
            end
            chk("rnd_final_count", {23'd0, sample_count}, k);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sample_writer.md
# sample_writer

Loads training samples (x1, x2, t) into the 7-bit sample memory that the regression datapath's reader later streams back. It is the write side of that memory, filled by the host before training starts. It accepts one sample per valid/ready handshake, packs each sample into three consecutive 7-bit words (x1, x2, t sign-extended), and reports how many samples were stored. The reader uses that count to raise its end-of-data indication.

## Interface
- MAX_SAMPLES, 100: capacity in samples; the memory holds 3*MAX_SAMPLES words.
- ADDR_W, 9: memory address width; 2^ADDR_W must be at least 3*MAX_SAMPLES.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: clear counters and arm loading.
- s_valid  in  1  host sample valid.
- s_ready  out  1  writer can accept a sample.
- s_x1  in  7  signed feature x1.
- s_x2  in  7  signed feature x2.
- s_t  in  2  signed target; only 2'b01 (+1) and 2'b11 (-1) are legal.
- s_last  in  1  marks the final sample of the set.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_data  out  7  memory write data.
- sample_count  out  ADDR_W  number of completely written samples.
- busy  out  1  high in the LOAD, WX1, WX2 and WT states.
- done  out  1  load complete; held until start or rst.
- full  out  1  sample_count == MAX_SAMPLES; sticky until start or rst.
- err_target  out  1  one-cycle pulse: a sample with an illegal t was rejected.

## Operation
- States:
  - IDLE: s_ready=0.
  - LOAD: s_ready=1.
  - WX1, WX2, WT: writing one sample; s_ready=0.
  - DONE: done=1, s_ready=0.
- IDLE -> LOAD on start.
- In LOAD, a handshake is s_valid && s_ready.
  - On a handshake, x1, x2, t and last are captured into holding registers.
  - A legal t moves the FSM to WX1.
  - An illegal t (2'b00 or 2'b10) drops the sample, pulses err_target in the next cycle, and the FSM stays in LOAD. sample_count and the address do not change.
- WX1 writes mem_data=x1 at address 3*sample_count. WX2 writes x2 at +1. WT writes {{5{t[1]}},t} at +2.
- WT has three exits, evaluated in this priority:
  - sample_count increments, then:
  - the new count equals MAX_SAMPLES: go to DONE and set full.
  - else the captured last is set: go to DONE.
  - else: go to LOAD.
- DONE holds until start. start in DONE clears the counters and goes to LOAD.
- start in any state, including mid-write, has the same effect:
  - sample_count=0, full=0, done=0, next state LOAD.
  - A partially written sample is abandoned, is not counted, and is overwritten later.
  - start has priority over the handshake in the same cycle; that sample is not accepted.
- s_valid is ignored in IDLE, WX1, WX2, WT and DONE.
- mem_we is high only in WX1, WX2 and WT. mem_addr and mem_data are don't-care when mem_we=0 but are driven to 0.

## Timing
- Reset values: state IDLE; s_ready, mem_we, mem_addr, mem_data, sample_count, busy, done, full and err_target all 0.
- Handshake in cycle N -> mem_we high in N+1, N+2 and N+3 -> sample_count updated and visible in N+4.
- s_ready returns in N+4 when more samples are allowed. Peak throughput is one sample per 4 cycles.
- done and full rise in N+4 after the terminating sample.
- err_target is high exactly in cycle N+1 after a rejected handshake. s_ready stays high throughout.
- start in cycle N -> s_ready=1 in N+1.
- rst overrides start and the handshake in the same cycle.

## Test plan
- Reset, then start, then 3 samples ((5,-3,+1), (-64,63,-1), (0,1,+1), last on the third):
  - Writes at addresses 0..8 with data 5, 0x7D, 0x01, 0x40, 0x3F, 0x7F, 0, 1, 0x01.
  - sample_count=3, done=1, full=0.
- MAX_SAMPLES=4, 6 samples offered back to back with no last:
  - Exactly 4 samples written (12 writes).
  - full=1 and done=1 four cycles after the 4th handshake.
  - s_ready stays 0 afterwards.
- Sample with t=2'b10 between two legal samples:
  - err_target pulses once.
  - No write for the rejected sample; the second legal sample lands at addresses 3..5.
  - sample_count=2.
- start asserted in WX2 of sample 2:
  - sample_count=0 and the next accepted sample is written at address 0.
  - No write issued in the cycle after start.
- s_valid held high in IDLE and DONE: no handshake and no write occurs.
- rst asserted during WT: all outputs 0 in the next cycle and sample_count is not incremented.
